// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morse_pkg
// Description : Shared definitions for the single-key Morse front end and the
//               downstream input FSM / decoder.
// Revision    : 1.0  initial release
// ============================================================================
package morse_pkg;

    // Symbols per character accepted downstream; sym_cnt saturates here.
    localparam logic [2:0] MORSE_MAX_SYMS = 3'd5;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PRESS = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        MORSE_IDLE  = c_ST_IDLE,
        MORSE_PRESS = c_ST_PRESS,
        MORSE_GAP   = c_ST_GAP
    } morse_state_e;

endpackage
`default_nettype wire

// File: rtl/morse_debounce.sv
`default_nettype none
// ============================================================================
// Module      : morse_debounce
// Description : Two-flop synchroniser plus stable-count debouncer for a raw key.
// Revision    : 1.0  initial release
// ============================================================================
module morse_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_i,
    output logic key_db_o
);

    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    logic             sync1_q;
    logic             sync_q;
    logic             db_q;
    logic [CNT_W-1:0] deb_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync_q    <= 1'b0;
            db_q      <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= key_raw_i;
            sync_q  <= sync1_q;
            // Any cycle where the synced level agrees with key_db restarts the count.
            if (sync_q != db_q) begin
                if (deb_cnt_q == c_DEB_LAST) begin
                    db_q      <= sync_q;
                    deb_cnt_q <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + c_ONE;
                end
            end else begin
                deb_cnt_q <= '0;
            end
        end
    end

    assign key_db_o = db_q;

endmodule
`default_nettype wire

// File: rtl/morse_key_timer.sv
`default_nettype none
// ============================================================================
// Module      : morse_key_timer
// Description : Single straight-key Morse front end: times presses and gaps and
//               emits one-cycle dot, dash and enter pulses.
// Revision    : 1.0  initial release
// ============================================================================
module morse_key_timer
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DASH_CYCLES     = 6000000,
    parameter int GAP_CYCLES      = 12000000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_raw_i,
    output logic       dot_pulse_o,
    output logic       dash_pulse_o,
    output logic       enter_pulse_o,
    output logic       key_active_o,
    output logic [2:0] sym_cnt_o
);

    localparam logic [CNT_W-1:0] c_DASH    = CNT_W'(DASH_CYCLES);
    localparam logic [CNT_W-1:0] c_GAP     = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic             w_key_db;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q,   gap_cnt_d;
    logic             dot_q,       dot_d;
    logic             dash_q,      dash_d;
    logic             enter_q,     enter_d;
    logic [2:0]       sym_cnt_q,   sym_cnt_d;

    morse_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .key_raw_i (key_raw_i),
        .key_db_o  (w_key_db)
    );

    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        dot_d       = 1'b0;
        dash_d      = 1'b0;
        enter_d     = 1'b0;
        sym_cnt_d   = sym_cnt_q;

        case (state_q)
            c_ST_IDLE: begin
                if (w_key_db) begin
                    state_d     = c_ST_PRESS;
                    press_cnt_d = c_ONE;
                end
            end

            c_ST_PRESS: begin
                if (w_key_db) begin
                    if (press_cnt_q != c_CNT_MAX) begin
                        press_cnt_d = press_cnt_q + c_ONE;
                    end
                end else begin
                    // The fall-detect cycle counts as the first key-up cycle of the gap.
                    if (press_cnt_q < c_DASH) begin
                        dot_d = 1'b1;
                    end else begin
                        dash_d = 1'b1;
                    end
                    if (sym_cnt_q != MORSE_MAX_SYMS) begin
                        sym_cnt_d = sym_cnt_q + 3'd1;
                    end
                    state_d     = c_ST_GAP;
                    press_cnt_d = '0;
                    gap_cnt_d   = c_ONE;
                end
            end

            c_ST_GAP: begin
                if (w_key_db) begin
                    state_d     = c_ST_PRESS;
                    press_cnt_d = c_ONE;
                    gap_cnt_d   = '0;
                end else if (gap_cnt_q == c_GAP) begin
                    enter_d   = 1'b1;
                    sym_cnt_d = 3'd0;
                    state_d   = c_ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + c_ONE;
                end
            end

            default: begin
                state_d     = c_ST_IDLE;
                press_cnt_d = '0;
                gap_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_ST_IDLE;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            dot_q       <= 1'b0;
            dash_q      <= 1'b0;
            enter_q     <= 1'b0;
            sym_cnt_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            press_cnt_q <= press_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            dot_q       <= dot_d;
            dash_q      <= dash_d;
            enter_q     <= enter_d;
            sym_cnt_q   <= sym_cnt_d;
        end
    end

    assign dot_pulse_o   = dot_q;
    assign dash_pulse_o  = dash_q;
    assign enter_pulse_o = enter_q;
    assign key_active_o  = w_key_db;
    assign sym_cnt_o     = sym_cnt_q;

endmodule
`default_nettype wire
